// File: rtl/emg_adc_pkg.sv
// Shared types and default sizing for the EMG ADC serial capture block.
package emg_adc_pkg;

  localparam int DEF_NUM_CH     = 16;
  localparam int DEF_ADC_BITS   = 12;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int CH_W           = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT,
    PUSH
  } emg_state_t;

  // Sample record at the default ADC width; the top packs {ch, data} the same way.
  typedef struct packed {
    logic [CH_W-1:0]         ch;
    logic [DEF_ADC_BITS-1:0] data;
  } emg_sample_t;

endpackage

// File: rtl/emg_cap_fifo.sv
// Small synchronous FIFO for captured samples; head is shown combinationally and reads as 0 when empty.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module emg_cap_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK_EMG,
  input  logic             RESET_N,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rd_en = pop & ~empty;
  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign wr_en = push & (~full | rd_en);
  assign rdata = empty ? '0 : mem[rd_ptr_q];

  // NOTE: storage has no reset; the empty flag masks stale entries, so only pointers need it.
  always_ff @(posedge CLK_EMG) begin
    if (wr_en) mem[wr_ptr_q] <= wdata;
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge CLK_EMG or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/emg_adc_capture.sv
// Serial EMG ADC capture: START-triggered MSB-first shift-in, sample FIFO, sticky error flags.
// Optional build macro EMG_CAP_PARITY_EN adds an even-parity bit after the LSB.
module emg_adc_capture
  import emg_adc_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int ADC_BITS   = DEF_ADC_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                CLK_EMG,
  input  logic                RESET_N,
  input  logic                EN_ADC_EMG,
  input  logic                START_EMG,
  input  logic [CH_W-1:0]     CH_SEL_EMG,
  input  logic                DOUT_EMG,
  output logic [ADC_BITS-1:0] SAMPLE_DATA,
  output logic [CH_W-1:0]     SAMPLE_CH,
  output logic                SAMPLE_VALID,
  input  logic                SAMPLE_READY,
  output logic                FRAME_DONE,
  output logic                OVF,
  output logic                SEQ_ERR,
  output logic                PAR_ERR,
  input  logic                ERR_CLR
);

`ifdef EMG_CAP_PARITY_EN
  localparam int SHIFT_LEN = ADC_BITS + 1;
`else
  localparam int SHIFT_LEN = ADC_BITS;
`endif
  localparam int CNT_W = $clog2(SHIFT_LEN + 1);
  localparam int ENT_W = CH_W + ADC_BITS;

  emg_state_t           state_q, state_d;
  logic [CH_W-1:0]      ch_q;
  logic [SHIFT_LEN-1:0] shreg_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic                 start_cap, shift_en, push, seq_ev, ovf_ev, push_ok, pop;
  logic                 fifo_full, fifo_empty, frame_done_q, ovf_q, seq_err_q;
  logic [ADC_BITS-1:0]  cap_data;
  logic [ENT_W-1:0]     fifo_rdata;
`ifdef EMG_CAP_PARITY_EN
  logic                 par_ev, par_err_q;
`endif

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    start_cap = 1'b0;
    shift_en  = 1'b0;
    push      = 1'b0;
    seq_ev    = 1'b0;
`ifdef EMG_CAP_PARITY_EN
    par_ev    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (START_EMG && EN_ADC_EMG) begin
          start_cap = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: state_d = EN_ADC_EMG ? SHIFT : IDLE;
      SHIFT: begin
        if (!EN_ADC_EMG) begin
          state_d = IDLE;
        end else begin
          shift_en = 1'b1;
          if (bit_cnt_q == CNT_W'(SHIFT_LEN - 1)) state_d = PUSH;
        end
      end
      PUSH: begin
        state_d = IDLE;
`ifdef EMG_CAP_PARITY_EN
        // Data plus parity bit must hold an even number of ones.
        if (^shreg_q) par_ev = 1'b1;
        else          push   = 1'b1;
`else
        push = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == WAIT || state_q == SHIFT) && !EN_ADC_EMG) seq_ev = 1'b1;
    if (state_q != IDLE && START_EMG && EN_ADC_EMG)           seq_ev = 1'b1;
  end

  assign cap_data = shreg_q[SHIFT_LEN-1 -: ADC_BITS];
  assign pop      = SAMPLE_READY & ~fifo_empty;
  assign push_ok  = push & (~fifo_full | pop);
  assign ovf_ev   = push & fifo_full & ~pop;

  always_ff @(posedge CLK_EMG or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_cap) begin
        ch_q      <= CH_SEL_EMG;
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (shift_en) shreg_q <= {shreg_q[SHIFT_LEN-2:0], DOUT_EMG};
      frame_done_q <= push_ok && (ch_q == CH_W'(NUM_CH - 1));
      // A new event on the clearing edge wins, so no error is silently lost.
      ovf_q     <= (ovf_q & ~ERR_CLR) | ovf_ev;
      seq_err_q <= (seq_err_q & ~ERR_CLR) | seq_ev;
    end
  end

`ifdef EMG_CAP_PARITY_EN
  always_ff @(posedge CLK_EMG or negedge RESET_N) begin
    if (!RESET_N) par_err_q <= 1'b0;
    else          par_err_q <= (par_err_q & ~ERR_CLR) | par_ev;
  end
  assign PAR_ERR = par_err_q;
`else
  assign PAR_ERR = 1'b0;
`endif

  emg_cap_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK_EMG(CLK_EMG),
    .RESET_N(RESET_N),
    .push   (push),
    .pop    (pop),
    .wdata  ({ch_q, cap_data}),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign {SAMPLE_CH, SAMPLE_DATA} = fifo_rdata;
  assign SAMPLE_VALID = ~fifo_empty;
  assign FRAME_DONE   = frame_done_q;
  assign OVF          = ovf_q;
  assign SEQ_ERR      = seq_err_q;

endmodule

// File: tb/tb_emg_adc_capture.sv
// Self-checking bench for emg_adc_capture: directed scenarios with random data, transaction-level queue model.
module tb_emg_adc_capture;
  import emg_adc_pkg::*;

  localparam int NUM_CH = 16;
  localparam int B      = 12;
  localparam int DEPTH  = 4;
`ifdef EMG_CAP_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, en, start, dout, ready, err_clr;
  logic [3:0]   ch_sel;
  logic [B-1:0] sample_data;
  logic [3:0]   sample_ch;
  logic         sample_valid, frame_done, ovf, seq_err, par_err;

  int tests = 0;
  int fails = 0;
  int fd_count = 0;
  int pops = 0;
  emg_sample_t model_q[$];
  bit exp_ovf, exp_seq, exp_par;

  always #5 clk = ~clk;

  emg_adc_capture #(.NUM_CH(NUM_CH), .ADC_BITS(B), .FIFO_DEPTH(DEPTH)) dut (
    .CLK_EMG     (clk),
    .RESET_N     (rst_n),
    .EN_ADC_EMG  (en),
    .START_EMG   (start),
    .CH_SEL_EMG  (ch_sel),
    .DOUT_EMG    (dout),
    .SAMPLE_DATA (sample_data),
    .SAMPLE_CH   (sample_ch),
    .SAMPLE_VALID(sample_valid),
    .SAMPLE_READY(ready),
    .FRAME_DONE  (frame_done),
    .OVF         (ovf),
    .SEQ_ERR     (seq_err),
    .PAR_ERR     (par_err),
    .ERR_CLR     (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ovf"}, ovf, exp_ovf);
    check({tag, "_seq"}, seq_err, exp_seq);
    check({tag, "_par"}, par_err, exp_par);
  endtask

  // Consumer-side scoreboard: every handshake must deliver the oldest expected sample.
  always @(negedge clk) begin
    #1;
    if (frame_done) fd_count++;
    if (rst_n && sample_valid && ready) begin
      check("pop_expected", model_q.size() != 0, 1);
      if (model_q.size() != 0) begin
        check("pop_ch", sample_ch, model_q[0].ch);
        check("pop_data", sample_data, model_q[0].data);
        void'(model_q.pop_front());
        pops++;
      end
    end
  end

  // One conversion from START to the cycle after the FIFO write.
  task automatic convert(input logic [3:0] ch, input logic [B-1:0] data, input int abort_bit,
                         input bit dup_start, input bit clr_on_dup, input bit par_flip,
                         output bit accepted);
    bit room;
    accepted = 1'b0;
    @(negedge clk); start = 1'b1; en = 1'b1; ch_sel = ch; dout = 1'($urandom);
    @(negedge clk); start = dup_start; err_clr = clr_on_dup; ch_sel = 4'($urandom); dout = 1'($urandom);
    if (dup_start) exp_seq = 1'b1;
    for (int i = 0; i < B; i++) begin
      @(negedge clk);
      start = 1'b0; err_clr = 1'b0;
      dout  = data[B-1-i];
      if (i == abort_bit) begin
        en = 1'b0;
        @(negedge clk); en = 1'b1;
        exp_seq = 1'b1;
        return;
      end
    end
    if (PAR_ON) begin
      @(negedge clk); dout = (^data) ^ par_flip;
    end
    @(negedge clk);
    if (!ready) check("pre_push_valid", sample_valid, model_q.size() != 0);
    room = (model_q.size() < DEPTH) || (ready && model_q.size() > 0);
    if (PAR_ON && par_flip) exp_par = 1'b1;
    else if (room) begin
      model_q.push_back('{ch: ch, data: data});
      accepted = 1'b1;
    end else exp_ovf = 1'b1;
    @(negedge clk);
    check("frame_done", frame_done, accepted && (ch == 4'(NUM_CH - 1)));
    if (!ready) begin
      check("head_valid", sample_valid, model_q.size() != 0);
      if (model_q.size() != 0) begin
        check("head_ch", sample_ch, model_q[0].ch);
        check("head_data", sample_data, model_q[0].data);
      end
    end
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int k = 0; k < 40 && model_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("drain_left", model_q.size(), 0);
    check("drain_valid", sample_valid, 0);
  endtask

  task automatic clear_errors();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    exp_ovf = 1'b0; exp_seq = 1'b0; exp_par = 1'b0;
    check_flags("after_clr");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int fd0, pops0;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; dout = 1'b0; ready = 1'b0;
    err_clr = 1'b0; ch_sel = '0;
    exp_ovf = 1'b0; exp_seq = 1'b0; exp_par = 1'b0;
    #12;
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_ch", sample_ch, 0);
    check("rst_frame_done", frame_done, 0);
    check_flags("rst");
    @(negedge clk); rst_n = 1'b1;

    // Single capture with latency check against an empty FIFO.
    convert(4'd5, 12'hA5C, -1, 0, 0, 0, acc);
    check("first_accepted", acc, 1);
    check_flags("first");
    drain();

    // A full frame, consumer always ready.
    fd0 = fd_count; pops0 = pops;
    for (int c = 0; c < NUM_CH; c++) convert(4'(c), B'($urandom), -1, 0, 0, 0, acc);
    drain();
    check("frame_pulses", fd_count - fd0, 1);
    check("frame_pops", pops - pops0, NUM_CH);
    check_flags("frame");

    // Stalled consumer: first four kept, head steady, overflow flagged.
    ready = 1'b0;
    for (int n = 0; n < 6; n++) convert(4'($urandom_range(0, 14)), B'($urandom), -1, 0, 0, 0, acc);
    check_flags("ovf");
    pops0 = pops;
    drain();
    check("ovf_pops", pops - pops0, DEPTH);
    clear_errors();

    // Enable dropped on the fifth shift edge.
    convert(4'd2, B'($urandom), 4, 0, 0, 0, acc);
    repeat (B + 4) @(negedge clk);
    check("abort_valid", sample_valid, 0);
    check_flags("abort");
    clear_errors();

    // Second START in WAIT, coinciding with ERR_CLR: flag stays, sample intact.
    convert(4'd7, B'($urandom), -1, 1, 1, 0, acc);
    check_flags("dup");
    drain();
    clear_errors();

    // Reset in the middle of SHIFT with samples and a flag pending.
    ready = 1'b0;
    convert(4'd1, B'($urandom), -1, 0, 0, 0, acc);
    convert(4'd4, B'($urandom), -1, 1, 0, 0, acc);
    @(negedge clk); start = 1'b1; en = 1'b1; ch_sel = 4'd3;
    @(negedge clk); start = 1'b0;
    repeat (5) begin @(negedge clk); dout = 1'($urandom); end
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    exp_ovf = 1'b0; exp_seq = 1'b0; exp_par = 1'b0;
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_data", sample_data, 0);
    check("mid_rst_ch", sample_ch, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check_flags("mid_rst");
    @(negedge clk); rst_n = 1'b1;
    repeat (B + 4) begin @(negedge clk); dout = 1'($urandom); end
    check("post_rst_idle", sample_valid, 0);
    convert(4'd9, B'($urandom), -1, 0, 0, 0, acc);
    check("post_rst_accepted", acc, 1);
    drain();

`ifdef EMG_CAP_PARITY_EN
    ready = 1'b0;
    convert(4'd1, 12'h001, -1, 0, 0, 1, acc);
    check("par_bad_valid", sample_valid, 0);
    check_flags("par_bad");
    clear_errors();
    convert(4'd1, 12'h001, -1, 0, 0, 0, acc);
    check("par_good_accepted", acc, 1);
    check_flags("par_good");
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
